// File: rtl/cntclk_sched_if.sv
// cntclk_sched_if: requester/divider-side bus of the reload scheduler.
interface cntclk_sched_if #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) ();
    logic [NREQ-1:0]       i_req;
    logic [NREQ*WIDTH-1:0] i_req_value;
    logic [NREQ-1:0]       i_req_sync;
    logic                  i_zero;
    logic                  o_load;
    logic [WIDTH-1:0]      o_value_drv;
    logic                  o_value_oe;
    logic [NREQ-1:0]       o_ack;
    logic [IDW-1:0]        o_grant_id;
    logic                  o_busy;
    logic                  o_forced;

    modport master (
        output i_req, i_req_value, i_req_sync, i_zero,
        input  o_load, o_value_drv, o_value_oe, o_ack, o_grant_id, o_busy, o_forced
    );

    modport slave (
        input  i_req, i_req_value, i_req_sync, i_zero,
        output o_load, o_value_drv, o_value_oe, o_ack, o_grant_id, o_busy, o_forced
    );
endinterface

// File: rtl/cntclk_sched.sv
// cntclk_sched: round-robin reload scheduler driving a compare-counter divider's
// load strobe, optionally aligned to the divider's zero event with a timeout fallback.
module cntclk_sched #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input logic           i_clk,
    input logic           i_rst_n,
    cntclk_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, WAIT_ZERO, LOAD, SETTLE, ACK} state_t;

    localparam logic [WIDTH:0] TMO = {1'b1, {WIDTH{1'b0}}};

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_q, rr_d, grant_q, grant_d, pick;
    logic [WIDTH-1:0] value_q, value_d;
    logic [WIDTH:0]   cnt_q, cnt_d;
    logic             forced_q, forced_d, found;

    // Scan downwards so the lowest offset from rr_q is the final winner.
    always_comb begin
        pick  = rr_q;
        found = 1'b0;
        for (int k = NREQ-1; k >= 0; k--) begin
            int j;
            j = int'(rr_q) + k;
            j = j >= NREQ ? j - NREQ : j;
            if (bus.i_req[j]) begin
                pick  = IDW'(j);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        grant_d  = grant_q;
        value_d  = value_q;
        cnt_d    = cnt_q;
        forced_d = 1'b0;
        case (state_q)
            IDLE: if (found) begin
                grant_d = pick;
                value_d = bus.i_req_value[pick*WIDTH +: WIDTH];
                cnt_d   = '0;
                state_d = bus.i_req_sync[pick] ? WAIT_ZERO : LOAD;
            end
            WAIT_ZERO: begin
                cnt_d    = cnt_q + 1'b1;
                state_d  = bus.i_zero || cnt_q == TMO ? LOAD : WAIT_ZERO;
                forced_d = !bus.i_zero && cnt_q == TMO;
            end
            LOAD:    state_d = SETTLE;
            SETTLE:  state_d = ACK;
            ACK: begin
                rr_d    = grant_q == IDW'(NREQ-1) ? '0 : grant_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            rr_q     <= '0;
            grant_q  <= '0;
            value_q  <= '0;
            cnt_q    <= '0;
            forced_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            grant_q  <= grant_d;
            value_q  <= value_d;
            cnt_q    <= cnt_d;
            forced_q <= forced_d;
        end
    end

    assign bus.o_load      = state_q == LOAD;
    assign bus.o_value_oe  = state_q == LOAD;
    assign bus.o_value_drv = state_q == LOAD ? value_q : '0;
    assign bus.o_ack       = state_q == ACK ? NREQ'(1) << grant_q : '0;
    assign bus.o_grant_id  = grant_q;
    assign bus.o_busy      = state_q != IDLE;
    assign bus.o_forced    = forced_q;
endmodule

// File: tb/tb_cntclk_sched.sv
// tb_cntclk_sched: scenario tasks with an expected-reload queue popped at each o_load.
module tb_cntclk_sched;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cntclk_sched_if #(.WIDTH(16), .NREQ(4), .IDW(2)) bus ();
    cntclk_sched_if #(.WIDTH(4), .NREQ(4), .IDW(2)) bus4 ();

    cntclk_sched #(.WIDTH(16), .NREQ(4), .IDW(2)) u_dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    cntclk_sched #(.WIDTH(4), .NREQ(4), .IDW(2)) u_dut4 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus4));

    typedef struct packed {
        logic [15:0] value;
        logic [1:0]  id;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic [3:0] one = 4'b0001;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.i_req = '0;
        bus4.i_req = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_load(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus.o_load === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        bus.i_req = '0; bus.i_req_value = '0; bus.i_req_sync = '0; bus.i_zero = 1'b0;
        bus4.i_req = '0; bus4.i_req_value = '0; bus4.i_req_sync = '0; bus4.i_zero = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.o_load, bus.o_value_oe, bus.o_value_drv, bus.o_forced} !== 19'd0) begin
            errors++; $display("FAIL reset_bus: got %h want 0", {bus.o_load, bus.o_value_oe, bus.o_value_drv, bus.o_forced});
        end
        checks++;
        if ({bus.o_ack, bus.o_grant_id, bus.o_busy} !== 7'd0) begin
            errors++; $display("FAIL reset_ctl: got %h want 0", {bus.o_ack, bus.o_grant_id, bus.o_busy});
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_immediate();
        bit ok;
        int c0;
        bus.i_req = 4'b0001; bus.i_req_value[15:0] = 16'h00FF; bus.i_req_sync = '0;
        sb.push_back('{16'h00FF, 2'd0});
        c0 = cyc;
        wait_load(4, ok);
        checks++;
        if (!ok || cyc - c0 != 1) begin
            errors++; $display("FAIL imm_latency: load ok=%0b after %0d cycles want 1", ok, cyc - c0); return;
        end
        e = sb.pop_front();
        checks++;
        if (bus.o_value_drv !== e.value || bus.o_value_oe !== 1'b1) begin
            errors++; $display("FAIL imm_value: got %h oe=%b want %h oe=1", bus.o_value_drv, bus.o_value_oe, e.value);
        end
        @(negedge clk);
        checks++;
        if (bus.o_load !== 1'b0 || bus.o_value_drv !== 16'h0 || bus.o_ack !== 4'b0) begin
            errors++; $display("FAIL imm_settle: load=%b drv=%h ack=%b want 0 0 0", bus.o_load, bus.o_value_drv, bus.o_ack);
        end
        @(negedge clk);
        checks++;
        if (bus.o_ack !== 4'b0001) begin
            errors++; $display("FAIL imm_ack: got %b want 0001", bus.o_ack);
        end
        bus.i_req = '0;
        @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++; $display("FAIL imm_busy: got %b want 0", bus.o_busy);
        end
    endtask

    task automatic test_round_robin();
        bit ok;
        int prev = 0;
        do_reset();
        bus.i_req_value = {16'h4003, 16'h4002, 16'h4001, 16'h4000};
        bus.i_req_sync = '0;
        bus.i_req = 4'b1111;
        foreach (sb[i]) sb.delete(i);
        for (int s = 0; s < 5; s++) sb.push_back('{16'h4000 + 16'(s % 4), 2'(s % 4)});
        for (int s = 0; s < 5; s++) begin
            wait_load(8, ok);
            checks++;
            if (!ok) begin
                errors++; $display("FAIL rr_load%0d: no load within budget", s); bus.i_req = '0; return;
            end
            e = sb.pop_front();
            checks++;
            if (bus.o_grant_id !== e.id || bus.o_value_drv !== e.value) begin
                errors++; $display("FAIL rr_grant%0d: got id=%0d val=%h want id=%0d val=%h", s, bus.o_grant_id, bus.o_value_drv, e.id, e.value);
            end
            repeat (2) @(negedge clk);
            checks++;
            if (bus.o_ack !== (one << e.id)) begin
                errors++; $display("FAIL rr_ack%0d: got %b want %b", s, bus.o_ack, one << e.id);
            end
            if (s > 0) begin
                checks++;
                if (cyc - prev != 4) begin
                    errors++; $display("FAIL rr_spacing%0d: got %0d want 4", s, cyc - prev);
                end
            end
            prev = cyc;
        end
        bus.i_req = '0;
        @(negedge clk);
    endtask

    task automatic test_sync();
        bit early = 1'b0;
        bit seen = 1'b0;
        bus.i_req_value[31:16] = 16'h0010; bus.i_req_sync = 4'b0010; bus.i_zero = 1'b0;
        bus.i_req = 4'b0010;
        sb.push_back('{16'h0010, 2'd1});
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            seen = bus.o_busy;
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL sync_grant: busy never rose"); bus.i_req = '0; return;
        end
        repeat (6) begin
            @(negedge clk);
            if (bus.o_load !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin
            errors++; $display("FAIL sync_early: load seen before zero, want none");
        end
        bus.i_zero = 1'b1;
        @(negedge clk);
        bus.i_zero = 1'b0;
        e = sb.pop_front();
        checks++;
        if (bus.o_load !== 1'b1 || bus.o_value_drv !== e.value || bus.o_grant_id !== e.id) begin
            errors++; $display("FAIL sync_load: load=%b val=%h id=%0d want 1 %h %0d", bus.o_load, bus.o_value_drv, bus.o_grant_id, e.value, e.id);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.o_ack !== 4'b0010) begin
            errors++; $display("FAIL sync_ack: got %b want 0010", bus.o_ack);
        end
        bus.i_req = '0; bus.i_req_sync = '0;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok = 1'b0;
        int n = 0;
        bus4.i_req_value[3:0] = 4'hA; bus4.i_req_sync = 4'b0001; bus4.i_zero = 1'b0;
        bus4.i_req = 4'b0001;
        sb.push_back('{16'h000A, 2'd0});
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus4.o_load === 1'b1) ok = 1'b1;
            else if (bus4.o_busy === 1'b1) n++;
        end
        e = sb.pop_front();
        checks++;
        if (!ok || n != 17) begin
            errors++; $display("FAIL tmo_wait: load=%0b after %0d wait cycles want 17", ok, n); bus4.i_req = '0; return;
        end
        checks++;
        if (bus4.o_forced !== 1'b1 || {12'h0, bus4.o_value_drv} !== e.value) begin
            errors++; $display("FAIL tmo_forced: forced=%b val=%h want 1 %h", bus4.o_forced, bus4.o_value_drv, e.value);
        end
        @(negedge clk);
        checks++;
        if (bus4.o_forced !== 1'b0) begin
            errors++; $display("FAIL tmo_pulse: forced=%b want 0", bus4.o_forced);
        end
        @(negedge clk);
        checks++;
        if (bus4.o_ack !== 4'b0001) begin
            errors++; $display("FAIL tmo_ack: got %b want 0001", bus4.o_ack);
        end
        bus4.i_req = '0; bus4.i_req_sync = '0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [3:0] ack_seen = '0;
        bus.i_req_value[47:32] = 16'h5555; bus.i_req_sync = '0;
        bus.i_req = 4'b0100;
        sb.push_back('{16'h5555, 2'd2});
        wait_load(4, ok);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL mid_load: no load within budget");
        end
        rst_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if ({bus.o_load, bus.o_value_oe, bus.o_busy} !== 3'b000) begin
            errors++; $display("FAIL mid_drop: load/oe/busy=%b want 000", {bus.o_load, bus.o_value_oe, bus.o_busy});
        end
        bus.i_req = '0;
        repeat (2) begin @(negedge clk); ack_seen |= bus.o_ack; end
        rst_n = 1'b1;
        repeat (3) begin @(negedge clk); ack_seen |= bus.o_ack; end
        checks++;
        if (ack_seen !== 4'b0) begin
            errors++; $display("FAIL mid_noack: got %b want 0000", ack_seen);
        end
        bus.i_req_value[47:32] = 16'h6666;
        bus.i_req = 4'b0100;
        sb.push_back('{16'h6666, 2'd2});
        wait_load(4, ok);
        e = sb.pop_front();
        checks++;
        if (!ok || bus.o_grant_id !== e.id || bus.o_value_drv !== e.value) begin
            errors++; $display("FAIL mid_reserve: ok=%0b id=%0d val=%h want id=%0d val=%h", ok, bus.o_grant_id, bus.o_value_drv, e.id, e.value);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.o_ack !== 4'b0100) begin
            errors++; $display("FAIL mid_ack: got %b want 0100", bus.o_ack);
        end
        bus.i_req = '0;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit ok;
        bus.i_req_value[15:0] = 16'h7000; bus.i_req_value[47:32] = 16'h7002; bus.i_req_sync = '0;
        bus.i_req = 4'b0101;
        sb.push_back('{16'h7000, 2'd0});
        sb.push_back('{16'h7002, 2'd2});
        sb.push_back('{16'h7000, 2'd0});
        for (int s = 0; s < 3; s++) begin
            wait_load(8, ok);
            e = sb.pop_front();
            checks++;
            if (!ok || bus.o_grant_id !== e.id || bus.o_value_drv !== e.value) begin
                errors++; $display("FAIL b2b_grant%0d: ok=%0b id=%0d val=%h want id=%0d val=%h", s, ok, bus.o_grant_id, bus.o_value_drv, e.id, e.value);
            end
            repeat (2) @(negedge clk);
            checks++;
            if (bus.o_ack !== (one << e.id)) begin
                errors++; $display("FAIL b2b_ack%0d: got %b want %b", s, bus.o_ack, one << e.id);
            end
        end
        bus.i_req = '0;
        @(negedge clk);
    endtask

    task automatic test_value_change();
        bit seen = 1'b0;
        do_reset();
        bus.i_zero = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0 || bus.o_load !== 1'b0) begin
            errors++; $display("FAIL zero_idle: busy=%b load=%b want 0 0", bus.o_busy, bus.o_load);
        end
        bus.i_zero = 1'b0;
        bus.i_req_value[31:16] = 16'h1234; bus.i_req_sync = 4'b0010;
        bus.i_req = 4'b0010;
        sb.push_back('{16'h1234, 2'd1});
        for (int i = 0; i < 4 && !seen; i++) begin
            @(negedge clk);
            seen = bus.o_busy;
        end
        bus.i_req_value[31:16] = 16'hBEEF;
        bus.i_req = '0;
        bus.i_zero = 1'b1;
        @(negedge clk);
        bus.i_zero = 1'b0;
        e = sb.pop_front();
        checks++;
        if (!seen || bus.o_load !== 1'b1 || bus.o_value_drv !== e.value || bus.o_grant_id !== e.id) begin
            errors++; $display("FAIL chg_load: load=%b val=%h id=%0d want 1 %h %0d", bus.o_load, bus.o_value_drv, bus.o_grant_id, e.value, e.id);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (bus.o_ack !== 4'b0010) begin
            errors++; $display("FAIL chg_ack: got %b want 0010", bus.o_ack);
        end
        @(negedge clk);
        checks++;
        if (bus.o_busy !== 1'b0) begin
            errors++; $display("FAIL chg_idle: busy=%b want 0", bus.o_busy);
        end
        bus.i_req_sync = '0;
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_round_robin();
        test_sync();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_value_change();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/cntclk_sched.md
# cntclk_sched

Reload scheduler for the compare-counter clock divider. Up to NREQ requesters share one divider; each asks to reload its compare value. The block arbitrates round-robin and drives the divider's load strobe and load-value bus for exactly one cycle. It applies the reload either immediately or aligned to the divider's next zero event, then acknowledges the winning requester.

## Interface
- WIDTH, 16, divider counter/compare value width
- NREQ, 4, number of requesters (2..8)
- IDW, 2, grant index width, ceil(log2(NREQ))

- i_clk  input  1  clock, shared with the divider
- i_rst_n  input  1  asynchronous active-low reset
- i_req  input  NREQ  per-requester level request, held until its o_ack
- i_req_value  input  NREQ*WIDTH  reload values, requester k at bits [k*WIDTH +: WIDTH], stable while i_req[k]=1
- i_req_sync  input  NREQ  1 = apply at next zero event, 0 = apply immediately
- i_zero  input  1  divider zero/restart indication
- o_load  output  1  divider load strobe, registered, one cycle high
- o_value_drv  output  WIDTH  value to place on the divider value bus
- o_value_oe  output  1  bus output enable, equals o_load
- o_ack  output  NREQ  one-hot, one-cycle acknowledge to the served requester
- o_grant_id  output  IDW  index of the requester currently being served
- o_busy  output  1  high in every state except IDLE
- o_forced  output  1  one-cycle pulse: a sync reload fell back to forced load after timeout

## Operation
- States: IDLE, WAIT_ZERO, LOAD, SETTLE, ACK.
- IDLE:
  - If any i_req bit is set, pick the first set bit at or after rr_ptr, wrapping modulo NREQ.
  - Latch grant index, value and sync flag.
  - Next state is WAIT_ZERO if the sync flag is set, otherwise LOAD.
- WAIT_ZERO:
  - Timeout counter is WIDTH+1 bits and is cleared on entry.
  - i_zero=1 → LOAD.
  - Counter reaching 2^WIDTH+1 → LOAD, with o_forced pulsed in the same cycle LOAD is entered.
- LOAD:
  - o_load=1, o_value_oe=1, o_value_drv = latched value.
  - → SETTLE.
- SETTLE: one cycle. The divider finishes setup; no bus drive. → ACK.
- ACK:
  - o_ack[grant]=1.
  - rr_ptr ← (grant+1) mod NREQ.
  - → IDLE.
- Latched value and grant are frozen from IDLE exit to ACK. Later i_req_value changes are ignored.
- A request dropped before being granted is never served.
- A request dropped after grant is still completed and acked.
- o_value_drv = 0 whenever o_value_oe=0.
- No requests are accepted while o_busy=1. There is at most one reload in flight.

## Timing
- Reset (async, immediate):
  - State IDLE, rr_ptr=0.
  - o_load=0, o_value_oe=0, o_value_drv=0, o_ack=0, o_grant_id=0, o_busy=0, o_forced=0.
- Immediate mode, request sampled in IDLE at edge n:
  - o_load high in cycle n+1.
  - SETTLE at n+2.
  - o_ack at n+3.
  - Back in IDLE at n+4, able to arbitrate at edge n+4.
- Sync mode:
  - i_zero sampled high at edge m (in WAIT_ZERO) → o_load at m+1, o_ack at m+3.
  - i_zero already high in the first WAIT_ZERO cycle counts as the zero event.
- o_grant_id is valid from the first cycle after IDLE exit through ACK, and holds its last value in IDLE.
- i_zero outside WAIT_ZERO is ignored.
- Simultaneous requests: only one is granted per service. The others wait; worst-case wait is NREQ-1 services.
- Reset asserted mid-operation (including during LOAD): outputs drop asynchronously and no ack is issued. Requesters must re-present their request.
- Back-to-back same requester: that requester re-enters arbitration with lowest priority next time.

## Test plan
- Reset, then i_req=4'b0001, value 16'h00FF, sync=0 at edge 0 → o_load=1 with o_value_drv=16'h00FF at cycle 1; o_ack=4'b0001 at cycle 3; o_busy low at cycle 4.
- i_req=4'b1111 held, all immediate → grants served in order 0,1,2,3,0. Each o_ack is 4 cycles apart and o_grant_id matches.
- Sync request (value 16'h0010) with i_zero pulsed 7 cycles after grant → o_load exactly one cycle after the i_zero edge; no load before it.
- Sync request with i_zero never asserted (WIDTH=4) → o_forced pulse and o_load after 17 WAIT_ZERO cycles; o_ack 2 cycles later.
- Assert i_rst_n=0 during LOAD → o_load, o_value_oe, o_busy go 0 immediately; no o_ack; after release a new request for requester 2 is served starting from rr_ptr=0.
- Requester 1 changes i_req_value and drops i_req right after grant → the originally latched value is loaded and o_ack[1] still pulses.
